uart_rx_frame_sequencer: RTL

- Parametrised receive-side frame sequencer for the UART Receive Engine.
- Replaces the fixed 8/9/10 bit-count decode with a runtime-configurable frame length: 5..MAX_DATA_BITS data bits, optional parity, 1 or 2 stop bits.
- Owns the start-bit detect, half-bit and full-bit baud timing, and bit counting.
- Emits mid-bit shift strobes to the receive shift register and a frame-done pulse to the status/flag logic.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_timer.sv | 32 +++
 rtl/uart_rx_frame_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: sequencer state encoding, frame-size limits and the
// frame-length helper used by both the receive and transmit sides.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RECV  = 2'd2,
        ST_DONE  = 2'd3
    } rx_state_e;

    localparam logic [3:0]  MIN_DATA_BITS = 4'd5;
    localparam int unsigned MIN_BAUD_K    = 2;

    // Total post-start bits: clamped data length, optional parity, 1 or 2 stop bits.
    function automatic logic [3:0] frame_len_calc(
        input logic [3:0] data_len,
        input logic       pen,
        input logic       two_stop,
        input logic [3:0] max_bits
    );
        logic [3:0] eff;
        if (data_len < MIN_DATA_BITS) begin
            eff = MIN_DATA_BITS;
        end else if (data_len > max_bits) begin
            eff = max_bits;
        end else begin
            eff = data_len;
        end
        return eff + {3'b000, pen} + (two_stop ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Loadable divisor counter: counts 0..limit-1 and ticks on the final count.
// Tick is combinational from the count; clr restarts the count from 0 next cycle.
module uart_baud_timer #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == limit - W'(1));
        cnt_d = cnt_q + W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame_sequencer.sv
// Receive frame sequencer: start-bit qualify at half bit, then one shift strobe per
// full bit until the latched frame length is reached; reset or enable low aborts.
module uart_rx_frame_sequencer
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int DIV_W         = 19,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_k,
    input  logic [3:0]       data_len,
    input  logic             pen,
    input  logic             two_stop,
    output logic             shift,
    output logic [CNT_W-1:0] bit_idx,
    output logic [CNT_W-1:0] frame_len,
    output logic             busy,
    output logic             frame_done,
    output logic             false_start
);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] frame_len_q, frame_len_d;
    logic [DIV_W-1:0] k_eff;
    logic [DIV_W-1:0] limit;
    logic             tick;
    logic             clr;

    // START times half a bit to land mid start-bit; everything else uses full bits.
    always_comb begin
        k_eff = (baud_k < DIV_W'(MIN_BAUD_K)) ? DIV_W'(MIN_BAUD_K) : baud_k;
        limit = (state_q == ST_START) ? (k_eff >> 1) : k_eff;
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        frame_len_d = frame_len_q;
        shift       = 1'b0;
        frame_done  = 1'b0;
        false_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx) begin
                    state_d     = ST_START;
                    bit_idx_d   = '0;
                    frame_len_d = CNT_W'(frame_len_calc(data_len, pen, two_stop,
                                                        4'(MAX_DATA_BITS)));
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx) begin
                        state_d     = ST_IDLE;
                        false_start = 1'b1;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (tick) begin
                    shift     = 1'b1;
                    bit_idx_d = bit_idx_q + CNT_W'(1);
                    if (bit_idx_d == frame_len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything, including strobes due this cycle.
        if (reset || !enable) begin
            state_d     = ST_IDLE;
            bit_idx_d   = '0;
            frame_len_d = '0;
            shift       = 1'b0;
            frame_done  = 1'b0;
            false_start = 1'b0;
        end

        clr = (state_d != state_q) || !enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            frame_len_q <= frame_len_d;
        end
    end

    uart_baud_timer #(
        .W (DIV_W)
    ) u_baud_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .limit (limit),
        .tick  (tick)
    );

    assign busy      = (state_q != ST_IDLE);
    assign bit_idx   = bit_idx_q;
    assign frame_len = frame_len_q;

endmodule
